// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch debouncer: default stability windows and counter sizing.
package sw_debounce_pkg;

    localparam int unsigned DEB_WIDTH_DEFAULT     = 8;
    localparam int unsigned DEB_SIM_STABLE_CYCLES = 4;
    // 50000 clocks at 50 MHz is roughly 1 ms of settle time.
    localparam int unsigned DEB_BOARD_STABLE_CYCLES = 50000;

    function automatic int unsigned deb_cnt_width(input int unsigned stable_cycles);
        int unsigned w;
        w = $clog2(stable_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch bank bundle: raw levels in, debounced levels and edge pulses out.
interface sw_debounce_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (output sw, input deb, input rise, input fall);
    modport slave  (input sw, output deb, output rise, output fall);
endinterface

// File: rtl/sw_debounce_debounce1.sv
// Single switch channel: 2-flop synchronizer, stability counter and rise/fall pulses.
module debounce1
    import sw_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEB_SIM_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = deb_cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sw_q, sw_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Count consecutive disagreement; follow the input only after a full window.
    always_comb begin
        cnt_d  = '0;
        sw_d   = sw_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q != sw_q) begin
            if (cnt_q == CNT_LAST) begin
                sw_d   = s2_q;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            sw_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= sw_i;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            sw_q   <= sw_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_o   = sw_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Bank of independent switch debouncers feeding the downstream inverter stage.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH         = DEB_WIDTH_DEFAULT,
    parameter int unsigned STABLE_CYCLES = DEB_BOARD_STABLE_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_sw,
    output logic [WIDTH-1:0] o_sw,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    if (STABLE_CYCLES < 1) begin : gen_bad_stable_cycles
        $error("sw_debounce: STABLE_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gen_deb1s
        debounce1 #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_deb1 (
            .clk   (i_clk),
            .rst_n (i_rst_n),
            .sw_i  (i_sw[i]),
            .sw_o  (o_sw[i]),
            .rise_o(o_rise[i]),
            .fall_o(o_fall[i])
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce at WIDTH=4, STABLE_CYCLES=4.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned SC = DEB_SIM_STABLE_CYCLES;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    sw_debounce_if #(.WIDTH(W)) bus ();

    sw_debounce #(
        .WIDTH        (W),
        .STABLE_CYCLES(SC)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_sw   (bus.sw),
        .o_sw   (bus.deb),
        .o_rise (bus.rise),
        .o_fall (bus.fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, act, exp);
    endtask

    // Advance n rising edges, then settle just past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] s,
                           input logic [W-1:0] r, input logic [W-1:0] f);
        chk({tag, ".sw"},   bus.deb,  s);
        chk({tag, ".rise"}, bus.rise, r);
        chk({tag, ".fall"}, bus.fall, f);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Reset dominance with all switches held high.
        rst_n  = 1'b0;
        bus.sw = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_all("rst_hold", 4'h0, 4'h0, 4'h0);
        end
        rst_n = 1'b1;
        step(SC + 1);
        chk_all("rst_rel_pre", 4'h0, 4'h0, 4'h0);
        step(1);
        chk_all("rst_rel_rise", 4'hF, 4'hF, 4'h0);
        step(1);
        chk_all("rst_rel_after", 4'hF, 4'h0, 4'h0);

        // Return all to zero to exercise fall pulses.
        bus.sw = 4'h0;
        step(SC + 1);
        chk_all("fall_pre", 4'hF, 4'h0, 4'h0);
        step(1);
        chk_all("fall_all", 4'h0, 4'h0, 4'hF);
        step(1);
        chk_all("fall_after", 4'h0, 4'h0, 4'h0);

        // Clean step on bit 0.
        bus.sw = 4'b0001;
        step(SC + 1);
        chk_all("step_pre", 4'h0, 4'h0, 4'h0);
        step(1);
        chk_all("step_edge", 4'b0001, 4'b0001, 4'h0);
        step(1);
        chk_all("step_after", 4'b0001, 4'h0, 4'h0);

        // Bounce on bit 1: toggle every 2 cycles for 20 cycles.
        for (int i = 0; i < 10; i++) begin
            bus.sw[1] = ~bus.sw[1];
            for (int j = 0; j < 2; j++) begin
                step(1);
                chk_all("bounce", 4'b0001, 4'h0, 4'h0);
            end
        end
        bus.sw[1] = 1'b1;
        step(SC + 1);
        chk_all("bounce_pre", 4'b0001, 4'h0, 4'h0);
        step(1);
        chk_all("bounce_settle", 4'b0011, 4'b0010, 4'h0);
        step(1);
        chk_all("bounce_after", 4'b0011, 4'h0, 4'h0);

        // Glitch on bit 2 one cycle shorter than the window.
        bus.sw[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) bus.sw[2] = 1'b0;
            step(1);
            chk_all("glitch", 4'b0011, 4'h0, 4'h0);
        end

        // Settle o_sw=1000, then swap to 0100 in one edge.
        bus.sw = 4'b1000;
        step(SC + 2);
        chk_all("simul_setup", 4'b1000, 4'b1000, 4'b0011);
        step(1);
        bus.sw = 4'b0100;
        step(SC + 1);
        chk_all("simul_pre", 4'b1000, 4'h0, 4'h0);
        step(1);
        chk_all("simul_edge", 4'b0100, 4'b0100, 4'b1000);
        step(1);
        chk_all("simul_after", 4'b0100, 4'h0, 4'h0);

        // Reset mid-count on bit 0: progress discarded, full latency after release.
        bus.sw = 4'b0101;
        step(3);
        chk_all("midrst_count", 4'b0100, 4'h0, 4'h0);
        rst_n = 1'b0;
        step(1);
        chk_all("midrst_rst", 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;
        step(SC + 1);
        chk_all("midrst_pre", 4'h0, 4'h0, 4'h0);
        step(1);
        chk_all("midrst_edge", 4'b0101, 4'b0101, 4'h0);
        step(1);
        chk_all("midrst_after", 4'b0101, 4'h0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
